// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [31:0] ins_in;
    logic        zeroFlag;
    logic        PCEn;
    logic        IorD;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  PCSrc;
    logic        illegal;
    logic [3:0]  state;

    modport master (
        input  ins_in, zeroFlag,
        output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal, state
    );

    modport slave (
        output ins_in, zeroFlag,
        input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore main FSM plus ALU decoder for the multicycle MIPS core.
// Outputs are combinational from state/op/funct/zeroFlag; no backpressure, one state per clock.
module mips_multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE   = 4'd0,
    parameter bit         ILLEGAL_STALL = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q, state_d;
    logic [5:0] op_q, funct_q;
    logic       funct_legal;
    logic [2:0] rtype_alu;

    always_comb begin
        funct_legal = 1'b1;
        rtype_alu   = 3'b010;
        case (funct_q)
            6'b100000: rtype_alu = 3'b010;
            6'b100010: rtype_alu = 3'b110;
            6'b100100: rtype_alu = 3'b000;
            6'b100101: rtype_alu = 3'b001;
            6'b101010: rtype_alu = 3'b111;
            default:   funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op_q)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = funct_legal ? S_EXEC : S_ILLEGAL;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXEC:    state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ILLEGAL: state_d = ILLEGAL_STALL ? S_ILLEGAL : S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // op/funct are captured in FETCH because ins_in follows the advanced PC afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= state_t'(RESET_STATE);
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                op_q    <= bus.ins_in[31:26];
                funct_q <= bus.ins_in[5:0];
            end
        end
    end

    logic       pcen_c, iord_c, memwrite_c, irwrite_c, regdst_c, memtoreg_c;
    logic       regwrite_c, alusrca_c, illegal_c;
    logic [1:0] alusrcb_c, pcsrc_c;
    logic [2:0] aluctl_c;

    always_comb begin
        pcen_c     = 1'b0;
        iord_c     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        alusrca_c  = 1'b0;
        alusrcb_c  = 2'b00;
        aluctl_c   = 3'b000;
        pcsrc_c    = 2'b00;
        illegal_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb_c = 2'b01;
                aluctl_c  = 3'b010;
                irwrite_c = 1'b1;
                pcen_c    = 1'b1;
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                aluctl_c  = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                aluctl_c  = 3'b010;
            end
            S_MEMRD: iord_c = 1'b1;
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
            end
            S_EXEC: begin
                alusrca_c = 1'b1;
                aluctl_c  = rtype_alu;
            end
            S_ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
            end
            S_BRANCH: begin
                alusrca_c = 1'b1;
                aluctl_c  = 3'b110;
                pcsrc_c   = 2'b01;
                pcen_c    = (op_q == OP_BNE) ? ~bus.zeroFlag : bus.zeroFlag;
            end
            S_ADDIWB: regwrite_c = 1'b1;
            S_JUMP: begin
                pcsrc_c = 2'b10;
                pcen_c  = 1'b1;
            end
            S_ILLEGAL: illegal_c = 1'b1;
            default: ;
        endcase
    end

    // Write strobes are gated by reset so nothing commits while reset is held.
    assign bus.PCEn       = pcen_c & reset_n;
    assign bus.IRWrite    = irwrite_c & reset_n;
    assign bus.MemWrite   = memwrite_c & reset_n;
    assign bus.RegWrite   = regwrite_c & reset_n;
    assign bus.illegal    = illegal_c & reset_n;
    assign bus.IorD       = iord_c;
    assign bus.RegDst     = regdst_c;
    assign bus.MemtoReg   = memtoreg_c;
    assign bus.ALUSrcA    = alusrca_c;
    assign bus.ALUSrcB    = alusrcb_c;
    assign bus.ALUControl = aluctl_c;
    assign bus.PCSrc      = pcsrc_c;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction expected output sequences, compared every cycle.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic [1:0] pcsrc;
        logic       ill;
    } rec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    rec_t mq[$];
    rec_t act;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl #(.RESET_STATE(4'd0), .ILLEGAL_STALL(1'b0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign act = '{st: bus.state, pcen: bus.PCEn, iord: bus.IorD, memwrite: bus.MemWrite,
                   irwrite: bus.IRWrite, regdst: bus.RegDst, memtoreg: bus.MemtoReg,
                   regwrite: bus.RegWrite, srca: bus.ALUSrcA, srcb: bus.ALUSrcB,
                   aluc: bus.ALUControl, pcsrc: bus.PCSrc, ill: bus.illegal};

    task automatic chk(input bit ok, input string name, input int got, input int want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            rec_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle t=%0t state got %0d want %0d, outputs got %h want %h",
                         $time, act.st, e.st, act, e);
            end
        end
    end

    function automatic rec_t reset_rec();
        rec_t r = '0;
        r.srcb = 2'b01;
        r.aluc = 3'b010;
        return r;
    endfunction

    // Expected per-cycle outputs for one instruction, from the instruction's semantics.
    task automatic build(input logic [31:0] w, input logic zf);
        rec_t r;
        logic [5:0] op, fn;
        logic [2:0] alu;
        bit legal_fn;
        op = w[31:26];
        fn = w[5:0];
        mq.delete();
        r = '0; r.st = 0; r.pcen = 1; r.irwrite = 1; r.srcb = 2'b01; r.aluc = 3'b010; mq.push_back(r);
        r = '0; r.st = 1; r.srcb = 2'b11; r.aluc = 3'b010; mq.push_back(r);
        legal_fn = 1'b1;
        alu = 3'b010;
        case (fn)
            6'h20: alu = 3'b010;
            6'h22: alu = 3'b110;
            6'h24: alu = 3'b000;
            6'h25: alu = 3'b001;
            6'h2A: alu = 3'b111;
            default: legal_fn = 1'b0;
        endcase
        if (op == 6'h23 || op == 6'h2B) begin
            r = '0; r.st = 2; r.srca = 1; r.srcb = 2'b10; r.aluc = 3'b010; mq.push_back(r);
            if (op == 6'h23) begin
                r = '0; r.st = 3; r.iord = 1; mq.push_back(r);
                r = '0; r.st = 4; r.memtoreg = 1; r.regwrite = 1; mq.push_back(r);
            end else begin
                r = '0; r.st = 5; r.iord = 1; r.memwrite = 1; mq.push_back(r);
            end
        end else if (op == 6'h00 && legal_fn) begin
            r = '0; r.st = 6; r.srca = 1; r.aluc = alu; mq.push_back(r);
            r = '0; r.st = 7; r.regdst = 1; r.regwrite = 1; mq.push_back(r);
        end else if (op == 6'h04 || op == 6'h05) begin
            r = '0; r.st = 8; r.srca = 1; r.aluc = 3'b110; r.pcsrc = 2'b01;
            r.pcen = (op == 6'h05) ? !zf : zf;
            mq.push_back(r);
        end else if (op == 6'h08) begin
            r = '0; r.st = 9; r.srca = 1; r.srcb = 2'b10; r.aluc = 3'b010; mq.push_back(r);
            r = '0; r.st = 10; r.regwrite = 1; mq.push_back(r);
        end else if (op == 6'h02) begin
            r = '0; r.st = 11; r.pcsrc = 2'b10; r.pcen = 1; mq.push_back(r);
        end else begin
            r = '0; r.st = 12; r.ill = 1; mq.push_back(r);
        end
    endtask

    task automatic cyc(input logic rst, input logic [31:0] ins, input logic zf, input rec_t e);
        @(posedge clk);
        #1;
        reset_n = rst;
        bus.ins_in = ins;
        bus.zeroFlag = zf;
        exp_q.push_back(e);
    endtask

    // zmode 0/1 forces zeroFlag in every cycle, 2 randomises it.
    task automatic run_instr(input logic [31:0] w, input int zmode, input int ncyc);
        logic zf;
        logic [31:0] junk;
        int n;
        zf = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        build(w, zf);
        n = (ncyc > 0 && ncyc < mq.size()) ? ncyc : mq.size();
        for (int i = 0; i < n; i++) begin
            junk = $urandom();
            cyc(1'b1, (i == 0) ? w : junk, (mq[i].st == 4'd8 || zmode != 2) ? zf : 1'($urandom_range(0, 1)), mq[i]);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0] fl [5];
        fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2A;
        r = $urandom();
        case ($urandom_range(0, 9))
            0: return {6'h23, r[25:0]};
            1: return {6'h2B, r[25:0]};
            2, 3: return {6'h00, r[25:6], fl[$urandom_range(0, 4)]};
            4: return {6'h04, r[25:0]};
            5: return {6'h05, r[25:0]};
            6: return {6'h08, r[25:0]};
            7: return {6'h02, r[25:0]};
            8: return {6'h00, r[25:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b1;
        bus.ins_in = '0;
        bus.zeroFlag = 1'b0;

        build(32'h8C220004, 0); chk(mq.size() == 5, "model_lw_cpi", mq.size(), 5);
        chk(mq[3].iord == 1, "model_lw_memrd_iord", mq[3].iord, 1);
        build(32'hAC220004, 0); chk(mq.size() == 4, "model_sw_cpi", mq.size(), 4);
        chk(mq[3].memwrite == 1, "model_sw_memwrite", mq[3].memwrite, 1);
        build(32'h00430820, 0); chk(mq.size() == 4, "model_add_cpi", mq.size(), 4);
        chk(mq[2].aluc == 3'b010, "model_add_aluc", mq[2].aluc, 2);
        build(32'h10220003, 1); chk(mq[2].pcen == 1 && mq[2].pcsrc == 2'b01, "model_beq_taken", mq[2].pcen, 1);
        build(32'h10220003, 0); chk(mq[2].pcen == 0, "model_beq_not_taken", mq[2].pcen, 0);
        build(32'h14220003, 0); chk(mq[2].pcen == 1, "model_bne_taken", mq[2].pcen, 1);
        build(32'h08000010, 0); chk(mq.size() == 3 && mq[2].pcsrc == 2'b10, "model_j", mq.size(), 3);
        build(32'hFC000000, 0); chk(mq.size() == 3 && mq[2].ill == 1, "model_illegal_op", mq.size(), 3);
        build(32'h0000003F, 0); chk(mq.size() == 3 && mq[2].st == 12, "model_illegal_funct", mq[2].st, 12);

        #1 reset_n = 1'b0;
        bus.ins_in = 'x;
        cyc(1'b0, 'x, 1'b0, reset_rec());
        cyc(1'b0, 'x, 1'b0, reset_rec());
        cyc(1'b0, 'x, 1'b0, reset_rec());

        run_instr(32'h00430820, 2, 0);
        run_instr(32'h8C220004, 2, 0);
        run_instr(32'hAC220004, 2, 0);
        run_instr(32'h10220003, 1, 0);
        run_instr(32'h10220003, 0, 0);
        run_instr(32'h14220003, 1, 0);
        run_instr(32'h14220003, 0, 0);
        run_instr(32'h08000010, 2, 0);
        run_instr(32'h20210005, 2, 0);
        run_instr(32'hFC000000, 2, 0);
        run_instr(32'h0000003F, 2, 0);

        // Reset asserted in the middle of the MEMRD cycle of a lw.
        run_instr(32'h8C220004, 2, 4);
        #6;
        reset_n = 1'b0;
        #1;
        chk(bus.state == 4'd0, "async_reset_state", bus.state, 0);
        chk(bus.RegWrite == 1'b0 && bus.PCEn == 1'b0, "async_reset_wr", bus.RegWrite, 0);
        cyc(1'b0, 32'h8C220004, 1'b0, reset_rec());
        cyc(1'b0, 32'h8C220004, 1'b0, reset_rec());
        run_instr(32'h00430820, 2, 0);

        for (int k = 0; k < 250; k++) run_instr(rand_instr(), 2, 0);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
